// File: rtl/nn_frame_driver_pkg.sv
// Shared types and sizing constants for the NN frame driver and its argmax helper.
package nn_frame_driver_pkg;

  localparam int INPUT_SIZE_DEF  = 16;
  localparam int OUTPUT_SIZE_DEF = 5;

  // Index width for an n-entry array; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IN_IDX_W  = idx_w(INPUT_SIZE_DEF);
  localparam int OUT_IDX_W = idx_w(OUTPUT_SIZE_DEF);

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_FIRE,
    ST_WAIT,
    ST_ARGMAX,
    ST_UNLOAD
  } state_t;

endpackage

// File: rtl/nn_frame_driver_if.sv
// Feature stream, network handshake and score stream of the NN frame driver.
interface nn_frame_driver_if
  import nn_frame_driver_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int INPUT_SIZE  = INPUT_SIZE_DEF,
  parameter int OUTPUT_SIZE = OUTPUT_SIZE_DEF
);

  logic                                s_valid;
  logic                                s_ready;
  logic [WIDTH-1:0]                    s_data;
  logic                                nn_input_ready;
  logic [INPUT_SIZE-1:0][WIDTH-1:0]    nn_input_data;
  logic                                nn_output_ready;
  logic [OUTPUT_SIZE-1:0][WIDTH-1:0]   nn_output_data;
  logic                                m_valid;
  logic                                m_ready;
  logic [WIDTH-1:0]                    m_data;
  logic                                m_last;
  logic [idx_w(OUTPUT_SIZE)-1:0]       m_class;
  logic                                busy;
  logic                                timeout_err;

  modport slave (
    input  s_valid, s_data, nn_output_ready, nn_output_data, m_ready,
    output s_ready, nn_input_ready, nn_input_data, m_valid, m_data, m_last, m_class,
           busy, timeout_err
  );

  modport master (
    output s_valid, s_data, nn_output_ready, nn_output_data, m_ready,
    input  s_ready, nn_input_ready, nn_input_data, m_valid, m_data, m_last, m_class,
           busy, timeout_err
  );

endinterface

// File: rtl/nn_frame_driver_argmax.sv
// Sequential argmax: one signed compare per cycle, strict greater-than so ties keep the lowest index.
module nn_argmax_seq
  import nn_frame_driver_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int N     = OUTPUT_SIZE_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [N-1:0][WIDTH-1:0]   scores,
  output logic                      done,
  output logic [idx_w(N)-1:0]       index
);

  localparam int IW = idx_w(N);

  logic                    run;
  logic [IW-1:0]           cnt;
  logic signed [WIDTH-1:0] best;

  assign done = run && (cnt == IW'(N-1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run   <= 1'b0;
      cnt   <= '0;
      best  <= '0;
      index <= '0;
    end else if (start) begin
      run <= 1'b1;
      cnt <= '0;
    end else if (run) begin
      if ((cnt == '0) || ($signed(scores[cnt]) > best)) begin
        best  <= $signed(scores[cnt]);
        index <= cnt;
      end
      if (done) run <= 1'b0;
      else      cnt <= cnt + IW'(1);
    end
  end

endmodule

// File: rtl/nn_frame_driver.sv
// Streams a feature frame into a neural network, waits for its scores, and streams them out with argmax.
//   state  | meaning
//   LOAD   | accept INPUT_SIZE features into the frame buffer
//   FIRE   | one-cycle start pulse to the network
//   WAIT   | wait for a rising result-ready edge, bounded by TIMEOUT
//   ARGMAX | sequential argmax over the captured scores
//   UNLOAD | stream scores out, class reported with the last one
module nn_frame_driver
  import nn_frame_driver_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int NFRAC       = 10,
  parameter int INPUT_SIZE  = INPUT_SIZE_DEF,
  parameter int OUTPUT_SIZE = OUTPUT_SIZE_DEF,
  parameter int TIMEOUT     = 1023
) (
  input  logic             clk,
  input  logic             reset,
  nn_frame_driver_if.slave bus
);

  localparam int IDX_W = idx_w(INPUT_SIZE);
  localparam int K_W   = idx_w(OUTPUT_SIZE);
  localparam int TW    = idx_w(TIMEOUT + 1);

  // Fixed-point position is carried by the data only; nothing here rescales.
  logic unused_nfrac;
  assign unused_nfrac = (NFRAC > 0);

  state_t                          state, state_nxt;
  logic [IDX_W-1:0]                idx;
  logic [K_W-1:0]                  k;
  logic [TW-1:0]                   wait_cnt;
  logic                            rdy_q;
  logic [INPUT_SIZE-1:0][WIDTH-1:0]  in_data;
  logic [OUTPUT_SIZE-1:0][WIDTH-1:0] scores;
  logic                            load_beat, last_feat, rise, capture, timeout_hit;
  logic                            unload_beat, last_score, am_done;
  logic [K_W-1:0]                  am_index;

  assign load_beat   = (state == ST_LOAD) && bus.s_valid;
  assign last_feat   = (idx == IDX_W'(INPUT_SIZE - 1));
  assign rise        = bus.nn_output_ready && !rdy_q;
  assign capture     = (state == ST_WAIT) && rise;
  assign timeout_hit = (state == ST_WAIT) && !rise && (wait_cnt == '0);
  assign last_score  = (k == K_W'(OUTPUT_SIZE - 1));
  assign unload_beat = (state == ST_UNLOAD) && bus.m_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_LOAD;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_LOAD:   if (load_beat && last_feat) state_nxt = ST_FIRE;
      ST_FIRE:   state_nxt = ST_WAIT;
      ST_WAIT:   if (capture) state_nxt = ST_ARGMAX;
                 else if (timeout_hit) state_nxt = ST_LOAD;
      ST_ARGMAX: if (am_done) state_nxt = ST_UNLOAD;
      ST_UNLOAD: if (unload_beat && last_score) state_nxt = ST_LOAD;
      default:   state_nxt = ST_LOAD;
    endcase
  end

  // rdy_q resets high so a result-ready level present at reset release is not a rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx         <= '0;
      k           <= '0;
      wait_cnt    <= '0;
      rdy_q       <= 1'b1;
      in_data     <= '0;
      scores      <= '0;
      bus.timeout_err <= 1'b0;
    end else begin
      rdy_q <= bus.nn_output_ready;
      if (load_beat) begin
        in_data[idx] <= bus.s_data;
        idx          <= last_feat ? '0 : idx + IDX_W'(1);
      end
      if (state == ST_FIRE)
        wait_cnt <= TW'(TIMEOUT - 1);
      else if ((state == ST_WAIT) && (wait_cnt != '0))
        wait_cnt <= wait_cnt - TW'(1);
      if (capture)     scores <= bus.nn_output_data;
      if (timeout_hit) bus.timeout_err <= 1'b1;
      if (unload_beat) k <= last_score ? '0 : k + K_W'(1);
    end
  end

  nn_argmax_seq #(
    .WIDTH (WIDTH),
    .N     (OUTPUT_SIZE)
  ) u_argmax (
    .clk    (clk),
    .reset  (reset),
    .start  (capture),
    .scores (scores),
    .done   (am_done),
    .index  (am_index)
  );

  assign bus.s_ready        = (state == ST_LOAD);
  assign bus.nn_input_ready = (state == ST_FIRE);
  assign bus.nn_input_data  = in_data;
  assign bus.m_valid        = (state == ST_UNLOAD);
  assign bus.m_data         = scores[k];
  assign bus.m_last         = (state == ST_UNLOAD) && last_score;
  assign bus.m_class        = bus.m_last ? am_index : '0;
  assign bus.busy           = (state != ST_LOAD);

endmodule

// File: tb/tb_nn_frame_driver.sv
// Randomized self-checking bench for nn_frame_driver against a frame-level reference model.
module tb_nn_frame_driver;
  import nn_frame_driver_pkg::*;

  localparam int W   = 16;
  localparam int NI  = 16;
  localparam int NO  = 5;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  nn_frame_driver_if #(.WIDTH(W), .INPUT_SIZE(NI), .OUTPUT_SIZE(NO)) io ();

  nn_frame_driver #(
    .WIDTH(W), .NFRAC(10), .INPUT_SIZE(NI), .OUTPUT_SIZE(NO), .TIMEOUT(TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (io)
  );

  int n_checks = 0;
  int n_errs   = 0;
  logic [W-1:0] feats [NI];
  logic [W-1:0] sc    [NO];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference argmax: find the maximum value, then the first position holding it.
  function automatic logic [OUT_IDX_W-1:0] exp_class();
    logic signed [W-1:0] mx;
    mx = sc[0];
    for (int i = 1; i < NO; i++) if ($signed(sc[i]) > mx) mx = sc[i];
    for (int i = 0; i < NO; i++) if ($signed(sc[i]) == mx) return OUT_IDX_W'(i);
    return '0;
  endfunction

  task automatic chk_frame(input string tag);
    for (int i = 0; i < NI; i++) chk(tag, 64'(io.nn_input_data[i]), 64'(feats[i]));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_s_ready"}, 64'(io.s_ready), 64'd1);
    chk({tag, "_busy"},    64'(io.busy),    64'd0);
    chk({tag, "_m_valid"}, 64'(io.m_valid), 64'd0);
    chk({tag, "_in_rdy"},  64'(io.nn_input_ready), 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    io.s_valid = 1'b0; io.s_data = '0; io.m_ready = 1'b0;
    io.nn_output_ready = 1'b0; io.nn_output_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic rand_feats();
    for (int i = 0; i < NI; i++) feats[i] = W'($urandom);
  endtask

  task automatic rand_scores();
    logic [W-1:0] pool [4];
    for (int j = 0; j < 4; j++) pool[j] = W'($urandom);
    for (int i = 0; i < NO; i++) sc[i] = pool[$urandom_range(0, 3)];
  endtask

  task automatic decoy_output();
    for (int i = 0; i < NO; i++) io.nn_output_data[i] = W'($urandom);
  endtask

  // Ends on the negedge of the FIRE cycle.
  task automatic send_frame(input bit gaps);
    for (int i = 0; i < NI; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          io.s_valid = 1'b0; io.s_data = W'($urandom);
          @(negedge clk);
        end
      end
      io.s_valid = 1'b1; io.s_data = feats[i];
      chk("s_ready_load", 64'(io.s_ready), 64'd1);
      chk("in_rdy_load",  64'(io.nn_input_ready), 64'd0);
      @(negedge clk);
    end
    io.s_valid = 1'b0;
    chk("in_rdy_fire", 64'(io.nn_input_ready), 64'd1);
    chk_frame("in_data_fire");
  endtask

  // hi: cycles a leftover result-ready level is held into WAIT; lo: low cycles before the real edge.
  task automatic respond(input int hi, input int lo, input bit spam);
    decoy_output();
    repeat (hi) begin
      @(negedge clk);
      chk("in_rdy_pulse", 64'(io.nn_input_ready), 64'd0);
      chk("m_valid_hi",   64'(io.m_valid), 64'd0);
    end
    io.nn_output_ready = 1'b0;
    repeat (lo) begin
      @(negedge clk);
      chk("in_rdy_pulse", 64'(io.nn_input_ready), 64'd0);
      chk("s_ready_wait", 64'(io.s_ready), 64'd0);
      chk("m_valid_wait", 64'(io.m_valid), 64'd0);
      if (spam) begin io.s_valid = 1'b1; io.s_data = W'($urandom); end
    end
    io.s_valid = 1'b0;
    for (int i = 0; i < NO; i++) io.nn_output_data[i] = sc[i];
    io.nn_output_ready = 1'b1;
    for (int c = 1; c <= NO; c++) begin
      @(negedge clk);
      if (c == 1) decoy_output();
      chk("m_valid_early", 64'(io.m_valid), 64'd0);
      chk("busy_argmax",   64'(io.busy), 64'd1);
    end
    @(negedge clk);
    chk("m_valid_start", 64'(io.m_valid), 64'd1);
  endtask

  // mode 0: always ready, 1: toggle starting stalled, 2: random.
  task automatic unload(input int mode);
    int   k   = 0;
    int   cyc = 0;
    logic tog = 1'b0;
    logic rdy;
    logic [OUT_IDX_W-1:0] cls = exp_class();
    while (k < NO && cyc < 60) begin
      chk("m_valid", 64'(io.m_valid), 64'd1);
      chk("m_data",  64'(io.m_data), 64'(sc[k]));
      chk("m_last",  64'(io.m_last), 64'(k == NO - 1));
      if (k == NO - 1) chk("m_class", 64'(io.m_class), 64'(cls));
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
      tog = ~tog;
      io.m_ready = rdy;
      @(negedge clk);
      cyc++;
      if (rdy) k++;
    end
    if (k < NO) chk("unload_bound", 64'(k), 64'(NO));
    io.m_ready = 1'b0;
    chk_idle("after_unload");
    chk_frame("in_data_hold");
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [IN_IDX_W-1:0] n_part;

    do_reset();
    chk_idle("rst");
    chk("rst_m_last",  64'(io.m_last), 64'd0);
    chk("rst_m_class", 64'(io.m_class), 64'd0);
    chk("rst_tmo",     64'(io.timeout_err), 64'd0);
    for (int i = 0; i < NI; i++) chk("rst_in_data", 64'(io.nn_input_data[i]), 64'd0);

    // Q6.10 features 1..16 back-to-back, then the tie score vector.
    for (int i = 0; i < NI; i++) feats[i] = W'(16'h0400 * (i + 1));
    send_frame(1'b0);
    sc[0] = 16'h0100; sc[1] = 16'h0C00; sc[2] = 16'hF800; sc[3] = 16'h0C00; sc[4] = 16'h0200;
    respond(0, 2, 1'b0);
    unload(0);

    // Result-ready still high from the previous frame; toggled sink stalls.
    rand_feats();
    send_frame(1'b1);
    rand_scores();
    respond(3, 1, 1'b1);
    unload(1);

    for (int f = 0; f < 6; f++) begin
      rand_feats();
      send_frame(1'b1);
      rand_scores();
      respond($urandom_range(0, 3), $urandom_range(1, 4), 1'($urandom_range(0, 1)));
      unload($urandom_range(0, 2));
    end

    // Result-ready never rises: timeout after TMO WAIT cycles.
    rand_feats();
    send_frame(1'b0);
    io.nn_output_ready = 1'b0;
    for (int i = 1; i <= TMO; i++) begin
      @(negedge clk);
      chk("tmo_m_valid", 64'(io.m_valid), 64'd0);
      chk("tmo_busy",    64'(io.busy), 64'd1);
      chk("tmo_early",   64'(io.timeout_err), 64'd0);
    end
    @(negedge clk);
    chk("tmo_set", 64'(io.timeout_err), 64'd1);
    chk_idle("tmo_back");

    rand_feats();
    send_frame(1'b1);
    rand_scores();
    respond(0, 2, 1'b0);
    unload(2);
    chk("tmo_sticky", 64'(io.timeout_err), 64'd1);

    // Reset after a partial frame of 7 features.
    rand_feats();
    n_part = IN_IDX_W'(7);
    for (int i = 0; i < int'(n_part); i++) begin
      io.s_valid = 1'b1; io.s_data = W'($urandom);
      @(negedge clk);
    end
    do_reset();
    chk_idle("midrst");
    chk("midrst_tmo", 64'(io.timeout_err), 64'd0);
    for (int i = 0; i < NI; i++) chk("midrst_in_data", 64'(io.nn_input_data[i]), 64'd0);
    send_frame(1'b0);
    rand_scores();
    respond(0, 1, 1'b0);
    unload(0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/nn_frame_driver.md
NN_FRAME_DRIVER -- requirements
Module: nn_frame_driver

Interface
REQ-001 SHALL have parameter WIDTH, default 16, sample word width (signed fixed point).
REQ-002 SHALL have parameter NFRAC, default 10, fractional bits (pass-through only; no rescaling).
REQ-003 SHALL have parameters INPUT_SIZE=16 (features per frame), OUTPUT_SIZE=5 (scores per frame), TIMEOUT=1023 (max WAIT cycles).
REQ-004 SHALL have one clock and an asynchronous, active-high reset:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have these ports:
- s_valid  in  1  feature word valid.
- s_ready  out  1  driver accepts a feature.
- s_data  in  WIDTH  signed feature.
- nn_input_ready  out  1  one-cycle start pulse to the network.
- nn_input_data  out  WIDTH x INPUT_SIZE  assembled frame.
- nn_output_ready  in  1  network result-ready level.
- nn_output_data  in  WIDTH x OUTPUT_SIZE  network scores.
- m_valid  out  1  score word valid.
- m_ready  in  1  sink accepts a score.
- m_data  out  WIDTH  signed score.
- m_last  out  1  final score of frame.
- m_class  out  clog2(OUTPUT_SIZE)  argmax index, valid with m_last.
- busy  out  1  state is not LOAD.
- timeout_err  out  1  sticky, set on WAIT timeout.

Function
REQ-006 SHALL implement states LOAD, FIRE, WAIT, ARGMAX, UNLOAD.
REQ-007 LOAD: s_ready=1; each s_valid&&s_ready beat writes s_data to nn_input_data[idx], idx increments 0..INPUT_SIZE-1.
REQ-008 Accepting beat INPUT_SIZE-1 SHALL move to FIRE next cycle and clear idx.
REQ-009 FIRE: nn_input_ready=1 for exactly one cycle, then WAIT; nn_input_data SHALL stay stable from FIRE until the next LOAD beat.
REQ-010 WAIT: capture nn_output_data into an internal score register only on a rising edge of nn_output_ready (previous-cycle sample 0, current 1); then go to ARGMAX.
REQ-011 A level-high nn_output_ready left over from a prior frame SHALL NOT trigger capture.
REQ-012 WAIT SHALL count cycles; at TIMEOUT with no capture, set timeout_err and return to LOAD with no output beats.
REQ-013 ARGMAX: one signed compare per cycle over OUTPUT_SIZE cycles; strict greater-than, so ties resolve to the lowest index; then UNLOAD.
REQ-014 UNLOAD: m_valid=1 and m_data=score[k], k from 0; advance k on m_valid&&m_ready.
REQ-015 m_last and m_class SHALL be valid when k=OUTPUT_SIZE-1; acceptance of that beat returns to LOAD.
REQ-016 m_data, m_last and m_class SHALL hold stable while m_valid&&!m_ready.
REQ-017 s_ready SHALL be 0 in every state except LOAD; s_data is ignored outside LOAD.
REQ-018 Frame-to-frame latency SHALL be: last feature accepted at cycle T, nn_input_ready at T+1, first m_valid OUTPUT_SIZE+1 cycles after capture.
REQ-019 timeout_err SHALL clear only on reset.

Reset
REQ-020 Reset SHALL force LOAD, idx=k=0, the WAIT counter to 0 and the edge-detect register to 1 (blocks a spurious first capture).
REQ-021 Reset SHALL force nn_input_data and scores to 0.
REQ-022 Reset SHALL force nn_input_ready, m_valid, m_last and timeout_err to 0, m_class to 0, and s_ready to 1 after release.
REQ-023 Reset mid-frame SHALL discard all partial frame and score state.

Structure
REQ-024 The shared package SHALL hold the state enum, INPUT_SIZE/OUTPUT_SIZE defaults and the index-width constants.
REQ-025 The argmax SHALL be a sub-module, nn_argmax_seq (start, scores, done, index).

Verification
REQ-026 Load features 1..16 (Q6.10: 0x0400*i) back-to-back -> nn_input_ready pulses one cycle after beat 16; nn_input_data[i]=0x0400*(i+1).
REQ-027 Scores {0x0100,0x0C00,0xF800,0x0C00,0x0200}, m_ready=1 -> 5 beats in order, m_last on beat 5, m_class=1 (tie, lowest index).
REQ-028 nn_output_ready held high through FIRE from the previous frame -> no capture until it falls and rises again.
REQ-029 nn_output_ready never rises, TIMEOUT=8 -> timeout_err=1 after 8 WAIT cycles, back in LOAD, no m_valid.
REQ-030 m_ready toggled 0/1 each cycle during UNLOAD -> every score is delivered exactly once, stable while stalled.
REQ-031 Reset asserted after 7 features -> s_ready=1 and idx=0; the next 16 beats form a clean frame.
